// File: rtl/delay_line_ctrl_if.sv
// Bus between the delay line controller, its sample source/sink and the dual-port delay RAM.
interface delay_line_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  // Sample stream
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] sample_in;
  logic        [ADDR_WIDTH-1:0] delay;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] sample_out;

  // RAM write port (a) and read port (b)
  logic [ADDR_WIDTH-1:0] mem_addr_a;
  logic [DATA_WIDTH-1:0] mem_data_a;
  logic                  mem_we_a;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic [DATA_WIDTH-1:0] mem_data_b;
  logic                  mem_we_b;
  logic [DATA_WIDTH-1:0] mem_q_b;

  // Controller side
  modport slave (
    input  in_valid, sample_in, delay, mem_q_b,
    output in_ready, out_valid, sample_out,
    output mem_addr_a, mem_data_a, mem_we_a, mem_addr_b, mem_data_b, mem_we_b
  );

  // Source/sink and RAM side
  modport master (
    output in_valid, sample_in, delay, mem_q_b,
    input  in_ready, out_valid, sample_out,
    input  mem_addr_a, mem_data_a, mem_we_a, mem_addr_b, mem_data_b, mem_we_b
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Delay line controller: each accepted sample is written to an external dual-port RAM and the
// sample written 'delay' samples earlier is returned. One sample per three cycles
// (IDLE -> RD -> WR), all outputs registered.
module delay_line_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  delay_line_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  // fill_cnt saturates at the RAM depth
  localparam logic [ADDR_WIDTH:0] FillMax = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_d, state_q;
  logic                  in_ready_d, in_ready_q;
  logic [DATA_WIDTH-1:0] sample_d, sample_q;
  logic [ADDR_WIDTH-1:0] delay_d, delay_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH:0]   fill_cnt_d, fill_cnt_q;
  logic [DATA_WIDTH-1:0] sample_out_d, sample_out_q;
  logic                  out_valid_d, out_valid_q;
  logic                  mem_we_a_d, mem_we_a_q;
  logic [ADDR_WIDTH-1:0] mem_addr_a_d, mem_addr_a_q;
  logic [DATA_WIDTH-1:0] mem_data_a_d, mem_data_a_q;
  logic [ADDR_WIDTH-1:0] mem_addr_b_d, mem_addr_b_q;

  // Next-state and registered-output logic of the accept/read/write sequence
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    sample_d     = sample_q;
    delay_d      = delay_q;
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    mem_we_a_d   = 1'b0;
    mem_addr_a_d = mem_addr_a_q;
    mem_data_a_d = mem_data_a_q;
    mem_addr_b_d = mem_addr_b_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          // Delay is captured only here, so changes while busy wait for the next accept
          sample_d     = bus.sample_in;
          delay_d      = bus.delay;
          mem_addr_b_d = wr_ptr_q - bus.delay;
          in_ready_d   = 1'b0;
          state_d      = StRd;
        end
      end
      StRd: begin
        mem_we_a_d   = 1'b1;
        mem_addr_a_d = wr_ptr_q;
        mem_data_a_d = sample_q;
        state_d      = StWr;
      end
      StWr: begin
        // RAM read data for the RD address is valid during this cycle
        if (delay_q == '0) begin
          sample_out_d = sample_q;
        end else if (fill_cnt_q < {1'b0, delay_q}) begin
          // Location not yet written since reset: contents are stale
          sample_out_d = '0;
        end else begin
          sample_out_d = bus.mem_q_b;
        end
        out_valid_d = 1'b1;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        fill_cnt_d  = (fill_cnt_q == FillMax) ? FillMax : fill_cnt_q + 1'b1;
        in_ready_d  = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = StIdle;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over everything, dropping any write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b1;
      sample_q     <= '0;
      delay_q      <= '0;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      mem_we_a_q   <= 1'b0;
      mem_addr_a_q <= '0;
      mem_data_a_q <= '0;
      mem_addr_b_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      sample_q     <= sample_d;
      delay_q      <= delay_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      mem_we_a_q   <= mem_we_a_d;
      mem_addr_a_q <= mem_addr_a_d;
      mem_data_a_q <= mem_data_a_d;
      mem_addr_b_q <= mem_addr_b_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sample_out = sample_out_q;
  assign bus.mem_we_a   = mem_we_a_q;
  assign bus.mem_addr_a = mem_addr_a_q;
  assign bus.mem_data_a = mem_data_a_q;
  assign bus.mem_addr_b = mem_addr_b_q;
  // Port b is read-only
  assign bus.mem_data_b = '0;
  assign bus.mem_we_b   = 1'b0;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl: directed scenarios push expected outputs and RAM writes
// into queues, a monitor on the falling edge pops and compares them.
module tb_delay_line_ctrl;

  logic clk;
  logic reset;

  delay_line_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dif ();

  delay_line_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  // Dual-port RAM model, preloaded with garbage so unmasked stale reads show up
  logic [15:0] mem [256] = '{default: 16'hDEAD};
  always @(posedge clk) begin
    if (dif.mem_we_a) mem[dif.mem_addr_a] <= dif.mem_data_a;
    dif.mem_q_b <= mem[dif.mem_addr_b];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  int n_acc  = 0;
  int n_out  = 0;
  bit started = 1'b0;

  logic [15:0] exp_q [$];
  int          acc_q [$];
  logic [15:0] wq    [$];
  logic [7:0]  exp_wptr = 8'd0;
  logic [15:0] last_out = 16'd0;
  logic [15:0] mon_e;
  int          mon_a;
  logic [15:0] mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output, write-port and hold monitor
  always @(negedge clk) begin
    if (started) begin
      if (dif.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out_valid actual=1 required=0 (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          n_out++;
          chk("sample_out", 32'(dif.sample_out), 32'(mon_e));
          chk("latency", 32'(cyc - mon_a + 1), 32'd3);
        end
      end
      if (dif.mem_we_a) begin
        if (wq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_mem_we_a actual=1 required=0 (t=%0t)", $time);
        end else begin
          mon_w = wq.pop_front();
          chk("mem_addr_a", 32'(dif.mem_addr_a), 32'(exp_wptr));
          chk("mem_data_a", 32'(dif.mem_data_a), 32'(mon_w));
          exp_wptr = exp_wptr + 8'd1;
        end
      end
      if (reset) last_out = 16'd0;
      else if (dif.out_valid) last_out = dif.sample_out;
      else chk("sample_out_hold", 32'(dif.sample_out), 32'(last_out));
    end
  end

  // Called at a falling edge; holds reset across two rising edges then checks reset state
  task automatic do_reset();
    reset = 1'b1;
    dif.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_sample_out", 32'(dif.sample_out), 32'd0);
    chk("rst_mem_we_a", 32'(dif.mem_we_a), 32'd0);
    chk("rst_mem_addr_a", 32'(dif.mem_addr_a), 32'd0);
    chk("rst_mem_addr_b", 32'(dif.mem_addr_b), 32'd0);
    chk("rst_mem_data_a", 32'(dif.mem_data_a), 32'd0);
    chk("rst_mem_we_b", 32'(dif.mem_we_b), 32'd0);
    chk("rst_mem_data_b", 32'(dif.mem_data_b), 32'd0);
    exp_q.delete();
    acc_q.delete();
    wq.delete();
    exp_wptr = 8'd0;
    started = 1'b1;
    reset = 1'b0;
  endtask

  // Offer a sample until accepted; returns at the falling edge after the accepting edge
  task automatic accept_s(input logic [15:0] s, input logic [7:0] d, output int acc);
    int budget = 0;
    dif.in_valid  = 1'b1;
    dif.sample_in = s;
    dif.delay     = d;
    while (!dif.in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!dif.in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept (t=%0t)", $time);
      acc = -1;
    end else begin
      acc = cyc + 1;
      wq.push_back(s);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] s, input logic [7:0] d, input logic [15:0] e,
                      output int acc);
    accept_s(s, d, acc);
    if (acc >= 0) begin
      exp_q.push_back(e);
      acc_q.push_back(acc);
      n_acc++;
    end
  endtask

  task automatic drain();
    int budget = 0;
    dif.in_valid = 1'b0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int prev;
    logic [15:0] v1 [6];
    logic [15:0] e1 [6];
    reset = 1'b1;
    dif.in_valid  = 1'b0;
    dif.sample_in = '0;
    dif.delay     = '0;
    @(negedge clk);

    // delay=3: 1..6 -> 0,0,0,1,2,3
    do_reset();
    v1 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    e1 = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 6; i++) send(v1[i], 8'd3, e1[i], acc);
    drain();

    // delay=0 bypass, RAM still written at address 0
    do_reset();
    send(16'h1234, 8'd0, 16'h1234, acc);
    drain();
    chk("bypass_ram_write", 32'(mem[0]), 32'h1234);

    // delay=255 over 300 samples, wr_ptr wraps
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(16'(i), 8'd255, (i < 255) ? 16'd0 : 16'(i - 255), acc);
    end
    drain();

    // in_valid held high: one accept every three cycles
    do_reset();
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send(16'(10 + i), 8'd1, (i == 0) ? 16'd0 : 16'(9 + i), acc);
      if (i > 0) chk("accept_spacing", 32'(acc - prev), 32'd3);
      prev = acc;
    end
    drain();

    // Reset in WR after five samples
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(21 + i), 8'd1, (i == 0) ? 16'd0 : 16'(20 + i), acc);
    drain();
    accept_s(16'd26, 8'd1, acc);
    dif.in_valid = 1'b0;
    @(negedge clk);
    chk("wr_state_we", 32'(dif.mem_we_a), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_drops_write", 32'(dif.mem_we_a), 32'd0);
    chk("reset_out_valid", 32'(dif.out_valid), 32'd0);
    chk("reset_in_ready", 32'(dif.in_ready), 32'd1);
    @(negedge clk);
    exp_q.delete();
    acc_q.delete();
    wq.delete();
    exp_wptr = 8'd0;
    reset = 1'b0;
    send(16'd31, 8'd1, 16'd0, acc);
    send(16'd32, 8'd1, 16'd31, acc);
    drain();

    // Delay change from 2 to 4 while in RD
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(1 + i), 8'd2, (i < 2) ? 16'd0 : 16'(i - 1), acc);
    send(16'd6, 8'd2, 16'd4, acc);
    dif.delay    = 8'd4;
    dif.in_valid = 1'b0;
    drain();
    send(16'd7, 8'd4, 16'd3, acc);
    drain();

    chk("pulse_count", 32'(n_out), 32'(n_acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/delay_line_ctrl.md
DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the audio sample width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the delay memory address width; depth is 2^ADDR_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning a new sample is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-007 The block SHALL have port sample_in, input, DATA_WIDTH, the signed input sample.
REQ-008 The block SHALL have port delay, input, ADDR_WIDTH, the delay in samples (0 to 2^ADDR_WIDTH-1).
REQ-009 The block SHALL have port out_valid, output, 1 bit, a one-cycle pulse qualifying sample_out.
REQ-010 The block SHALL have port sample_out, output, DATA_WIDTH, the delayed sample.
REQ-011 The block SHALL have ports mem_addr_a (output, ADDR_WIDTH), mem_data_a (output, DATA_WIDTH) and mem_we_a (output, 1), the write port to the dual-port RAM.
REQ-012 The block SHALL have ports mem_addr_b (output, ADDR_WIDTH), mem_data_b (output, DATA_WIDTH) and mem_we_b (output, 1), the read port to the RAM; mem_data_b and mem_we_b SHALL be tied to 0.
REQ-013 The block SHALL have port mem_q_b, input, DATA_WIDTH, the RAM read data, valid one clock after mem_addr_b is presented.

Function
REQ-014 The FSM SHALL have states IDLE, RD, WR; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept: in IDLE with in_valid=1, the block SHALL register sample_in and delay and go to RD on that edge.
REQ-016 In RD, mem_addr_b SHALL equal (wr_ptr - delay_reg) modulo 2^ADDR_WIDTH; the next state SHALL be WR.
REQ-017 In WR, mem_we_a SHALL be 1, mem_addr_a SHALL be wr_ptr and mem_data_a the registered sample; mem_we_a SHALL be 0 in all other states.
REQ-018 At the end of WR, the block SHALL register sample_out, increment wr_ptr modulo 2^ADDR_WIDTH (255 wraps to 0), and return to IDLE with out_valid=1 for exactly that one cycle.
REQ-019 Latency SHALL be 3 cycles from the accepting edge to the out_valid cycle; throughput SHALL be one sample per 3 cycles, with a new accept allowed in the out_valid cycle.
REQ-020 If delay_reg=0, sample_out SHALL be the registered input sample (bypass), not mem_q_b.
REQ-021 The block SHALL keep fill_cnt, ADDR_WIDTH+1 bits, incremented per written sample and saturating at 2^ADDR_WIDTH.
REQ-022 If delay_reg>0 and fill_cnt < delay_reg, sample_out SHALL be 0 (never-written RAM is not trusted); otherwise it SHALL be mem_q_b.
REQ-023 sample_out SHALL hold its value between out_valid pulses.
REQ-024 A change of delay while busy SHALL have no effect until the next accept.
REQ-025 in_valid while not in IDLE SHALL be ignored; the sample is not consumed.

Reset
REQ-026 When reset=1 at a rising edge, state SHALL become IDLE, and wr_ptr, fill_cnt, sample_out, out_valid, mem_we_a, mem_addr_a, mem_addr_b and mem_data_a SHALL become 0.
REQ-027 Reset SHALL take priority over all other activity, including mid-operation in RD or WR; a pending write in WR SHALL be dropped (mem_we_a=0 on the cycle after reset).
REQ-028 RAM contents SHALL NOT be cleared by reset; the fill_cnt masking of REQ-022 SHALL cover stale data.

Verification
REQ-029 Scenario: delay=3, feed samples 1,2,3,4,5,6 -> outputs 0,0,0,1,2,3, each out_valid exactly 3 cycles after its accept.
REQ-030 Scenario: delay=0, feed 0x1234 -> sample_out=0x1234 with one out_valid pulse; the RAM write to address 0 still occurs.
REQ-031 Scenario: delay=255, feed 300 samples valued 0..299 -> the first 255 outputs are 0, then 0,1,2,...; wr_ptr wraps 255->0 with no glitch.
REQ-032 Scenario: hold in_valid=1 continuously -> in_ready pulses one cycle in three; there are exactly N out_valid pulses for N accepts.
REQ-033 Scenario: assert reset during WR after 5 samples -> no mem_we_a on the next cycle; wr_ptr=0 and fill_cnt=0; with delay=1, the next two outputs are 0 then the first post-reset sample.
REQ-034 Scenario: change delay from 2 to 4 mid-operation (in RD) -> the current output uses delay 2 and the next accept uses delay 4.
